// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and divisor table for the clock divider.
// Optional macro CLKDIV_TICK_EN adds the tick strobe port.
package clkdiv_pkg;

  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    SEL_DIV2   = 2'b00,
    SEL_DIV3   = 2'b01,
    SEL_DIV10  = 2'b10,
    SEL_DIV100 = 2'b11
  } sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] DIV_TAB [4] = '{
    7'd2, 7'd3, 7'd10, 7'd100
  };

  function automatic logic [CNT_W-1:0] div_of(input sel_e s);
    return DIV_TAB[s];
  endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// clkdiv_counter: period counter, registered clk_out and tick.
// Macro CLKDIV_TICK_EN enables the tick output.
module clkdiv_counter
  import clkdiv_pkg::*;
(
  input  logic             clk_in,
  input  logic             reset,
  input  logic [CNT_W-1:0] n,
  input  logic             load,
  output logic             boundary,
  output logic             clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick
`endif
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] h;
  logic             live;
  logic             co_nxt;

  assign h        = n >> 1;
  assign boundary = live && (cnt == n - 7'd1);

  // next count; first edge after reset holds 0 so a period starts high
  always_comb begin
    cnt_nxt = cnt + 7'd1;
    if (!live || load || boundary) cnt_nxt = '0;
    co_nxt = (cnt_nxt < h);
  end

  // counter and output flop
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      live    <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_out <= co_nxt;
      live    <= 1'b1;
    end
  end

`ifdef CLKDIV_TICK_EN
  // strobe coincident with each clk_out rise
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) tick <= 1'b0;
    else        tick <= co_nxt & ~clk_out;
  end
`endif

endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: ratio-change FSM and request/ack handshake.
// Macro CLKDIV_TICK_EN adds the tick output.
module clkdiv_ctrl
  import clkdiv_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic       sel_req,
  input  logic [1:0] sel,
  output logic       sel_ack,
  output logic       busy,
  output logic [1:0] cur_sel,
  output logic       clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic       tick
`endif
);

  state_e state;
  sel_e   pend_sel;
  sel_e   cur;
  logic   boundary;
  logic   load;

  assign load    = (state == PEND) && boundary;
  assign cur_sel = cur;

  clkdiv_counter u_cnt (
    .clk_in   (clk_in),
    .reset    (reset),
    .n        (div_of(cur)),
    .load     (load),
    .boundary (boundary),
    .clk_out  (clk_out)
`ifdef CLKDIV_TICK_EN
    ,
    .tick     (tick)
`endif
  );

  // accept a request in RUN, apply it at the next period boundary
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      pend_sel <= SEL_DIV2;
      cur      <= SEL_DIV2;
      busy     <= 1'b0;
      sel_ack  <= 1'b0;
    end else begin
      sel_ack <= 1'b0;
      unique case (state)
        RUN: begin
          if (sel_req) begin
            pend_sel <= sel_e'(sel);
            busy     <= 1'b1;
            state    <= PEND;
          end
        end
        PEND: begin
          if (boundary) begin
            cur     <= pend_sel;
            sel_ack <= 1'b1;
            busy    <= 1'b0;
            state   <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed bench for clkdiv_ctrl.
// Define CLKDIV_TICK_EN to exercise the tick port.
module tb_clkdiv_ctrl;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       sel_req = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       sel_ack;
  logic       busy;
  logic [1:0] cur_sel;
  logic       clk_out;
`ifdef CLKDIV_TICK_EN
  logic       tick;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_ack = 0;
  int n_rise = 0;
  int n_tick = 0;
  int n_bad_tick = 0;
  int ack_at = 0;
  logic [31:0] co_v;
  logic [31:0] ack_v;
  logic [31:0] busy_v;
  logic prev_co = 1'b0;

  always #5 clk_in = ~clk_in;

  clkdiv_ctrl dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .sel_req (sel_req),
    .sel     (sel),
    .sel_ack (sel_ack),
    .busy    (busy),
    .cur_sel (cur_sel),
    .clk_out (clk_out)
`ifdef CLKDIV_TICK_EN
    ,
    .tick    (tick)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    co_v = '0;
    ack_v = '0;
    busy_v = '0;
    n_ack = 0;
    n_rise = 0;
    n_tick = 0;
    n_bad_tick = 0;
  endtask

  task automatic cap(input int n);
    repeat (n) begin
      @(negedge clk_in);
      cyc++;
      co_v = {co_v[30:0], clk_out};
      ack_v = {ack_v[30:0], sel_ack};
      busy_v = {busy_v[30:0], busy};
      if (sel_ack === 1'b1) begin
        n_ack++;
        ack_at = cyc;
      end
      if (clk_out === 1'b1 && prev_co === 1'b0) n_rise++;
`ifdef CLKDIV_TICK_EN
      if (tick === 1'b1) begin
        n_tick++;
        if (!(clk_out === 1'b1 && prev_co === 1'b0)) n_bad_tick++;
      end
`endif
      prev_co = clk_out;
    end
  endtask

  initial begin
    reset = 1'b0;
    #2;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(sel_ack), 32'd0);
    chk("rst_cur_sel", 32'(cur_sel), 32'd0);
`ifdef CLKDIV_TICK_EN
    chk("rst_tick", 32'(tick), 32'd0);
`endif
    @(negedge clk_in);
    reset = 1'b1;
    clr();
    cap(4);
    chk("div2_wave", co_v & 32'hF, 32'b1010);
    chk("div2_busy", busy_v & 32'hF, 32'd0);
    chk("div2_cur", 32'(cur_sel), 32'd0);

    sel = 2'b01;
    sel_req = 1'b1;
    clr();
    cap(1);
    sel_req = 1'b0;
    cap(8);
    chk("div3_wave", co_v & 32'h1FF, 32'b101001001);
    chk("div3_ack", ack_v & 32'h1FF, 32'b001000000);
    chk("div3_busy", busy_v & 32'h1FF, 32'b110000000);
    chk("div3_cur", 32'(cur_sel), 32'd1);

    sel = 2'b10;
    sel_req = 1'b1;
    clr();
    cap(1);
    sel_req = 1'b0;
    cap(12);
    chk("div10_wave", co_v & 32'h1FFF, 32'b0011111000001);
    chk("div10_ack", ack_v & 32'h1FFF, 32'b0010000000000);
    chk("div10_busy", busy_v & 32'h1FFF, 32'b1100000000000);
    chk("div10_cur", 32'(cur_sel), 32'd2);

    clr();
    cap(100);
    chk("div10_rises", 32'(n_rise), 32'd10);
    chk("div10_noack", 32'(n_ack), 32'd0);
`ifdef CLKDIV_TICK_EN
    chk("tick_count", 32'(n_tick), 32'd10);
    chk("tick_align", 32'(n_bad_tick), 32'd0);
`endif

    sel = 2'b11;
    sel_req = 1'b1;
    clr();
    cap(1);
    sel_req = 1'b0;
    cap(11);
    chk("div100_ack", ack_v & 32'hFFF, 32'b000000000100);
    chk("div100_ack_at", 32'(ack_at), 32'd136);
    chk("div100_cur", 32'(cur_sel), 32'd3);

    sel = 2'b00;
    sel_req = 1'b1;
    clr();
    cap(1);
    sel_req = 1'b0;
    cap(1);
    chk("pend_busy", 32'(busy), 32'd1);
    sel = 2'b11;
    sel_req = 1'b1;
    cap(1);
    sel_req = 1'b0;
    cap(104);
    chk("ign_n_ack", 32'(n_ack), 32'd1);
    chk("ign_ack_at", 32'(ack_at), 32'd236);
    chk("ign_cur", 32'(cur_sel), 32'd0);
    chk("ign_wave", co_v & 32'h3FF, 32'b1010101010);

    sel = 2'b11;
    sel_req = 1'b1;
    clr();
    cap(1);
    sel_req = 1'b0;
    cap(5);
    chk("bnd_ack_at", 32'(ack_at), 32'd248);
    chk("bnd_n_ack", 32'(n_ack), 32'd1);

    sel = 2'b10;
    sel_req = 1'b1;
    cap(1);
    sel_req = 1'b0;
    cap(3);
    chk("rp_busy", 32'(busy), 32'd1);
    chk("rp_clk_out", 32'(clk_out), 32'd1);
    reset = 1'b0;
    #2;
    chk("rp_rst_clk", 32'(clk_out), 32'd0);
    chk("rp_rst_busy", 32'(busy), 32'd0);
    chk("rp_rst_ack", 32'(sel_ack), 32'd0);
    chk("rp_rst_cur", 32'(cur_sel), 32'd0);
    @(negedge clk_in);
    reset = 1'b1;
    cyc = 0;
    prev_co = 1'b0;
    clr();
    cap(4);
    chk("rp_div2_wave", co_v & 32'hF, 32'b1010);
    cap(196);
    chk("rp_no_ack", 32'(n_ack), 32'd0);
    chk("rp_rises", 32'(n_rise), 32'd100);
    chk("rp_cur", 32'(cur_sel), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/clkdiv_ctrl.md
CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

Interface
REQ-001 The block SHALL have a single clock, clk_in, with all sequential logic on its rising edge.
REQ-002 reset SHALL be asynchronous and active-low; 0 forces reset immediately, independent of clk_in.
REQ-003 Ports SHALL be exactly as follows:
  clk_in   input   1  system clock, 100 MHz nominal
  reset    input   1  async active-low reset
  sel_req  input   1  request to change divide ratio, sampled each cycle
  sel      input   2  requested ratio: 00=div2 (50 MHz), 01=div3 (33.3 MHz, "30"), 10=div10, 11=div100
  sel_ack  output  1  one-cycle pulse when the requested ratio takes effect
  busy     output  1  ratio change pending
  cur_sel  output  2  ratio currently applied to clk_out
  clk_out  output  1  divided clock, driven directly by a flop
  tick     output  1  clk_out rising-edge strobe (present only with CLKDIV_TICK_EN)

Function
REQ-004 Divisor N SHALL come from cur_sel: 2, 3, 10, 100; high phase H = floor(N/2), low phase N-H cycles.
REQ-005 A 7-bit counter cnt SHALL run 0..N-1 and wrap to 0; a period boundary is the cycle in which cnt == N-1.
REQ-006 clk_out SHALL be registered: high while cnt is in 0..H-1 and low while cnt is in H..N-1, with no combinational path to the pin.
REQ-007 The FSM SHALL have two states: RUN and PEND.
REQ-008 In RUN with sel_req=1, the block SHALL latch sel into pend_sel, set busy=1 next cycle, and enter PEND.
REQ-009 In PEND at a period boundary, the block SHALL load cur_sel<=pend_sel, set cnt<=0 under the new N, pulse sel_ack for exactly 1 cycle, clear busy, and return to RUN.
REQ-010 A request accepted in the boundary cycle SHALL be applied at the following boundary, never the same one.
REQ-011 sel_req while in PEND SHALL be ignored; pend_sel SHALL NOT change. Requesters wait for busy=0.
REQ-012 A request with sel == cur_sel SHALL follow the normal PEND/ack sequence; clk_out stays continuous.
REQ-013 clk_out SHALL have no runt pulse or glitch across a ratio change: the old period completes fully before the new one begins.
REQ-014 Worst-case sel_req-to-sel_ack latency SHALL be 2 x 100 + 1 cycles.

Reset
REQ-015 While reset=0: clk_out=0, cnt=0, cur_sel=00, pend_sel=00, busy=0, sel_ack=0, tick=0, state=RUN.
REQ-016 Reset asserted during PEND SHALL discard the pending request with no sel_ack.
REQ-017 The first clk_in edge after reset release SHALL start a div2 period with clk_out=1.

Configuration
REQ-018 Macro CLKDIV_TICK_EN defined: the tick port exists and pulses 1 for one clk_in cycle, coincident with each 0->1 transition of clk_out, usable as a clock enable.
REQ-019 CLKDIV_TICK_EN undefined: the tick port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-020 Package clkdiv_pkg SHALL hold: the sel enum (SEL_DIV2, SEL_DIV3, SEL_DIV10, SEL_DIV100), the divisor constant table, the counter width constant (7), and the FSM state enum.
REQ-021 Sub-module clkdiv_counter SHALL contain the cnt/clk_out/tick datapath (inputs: N, load strobe; outputs: boundary, clk_out, tick).
REQ-022 clkdiv_ctrl SHALL hold the FSM and the request/ack handshake.

Verification
REQ-023 Reset pulse 10 ns, then release -> clk_out period 20 ns (10 ns high / 10 ns low), cur_sel=00, busy=0.
REQ-024 sel=10, sel_req 1 cycle -> busy=1 until boundary, one sel_ack pulse, cur_sel=10, then clk_out period 100 ns (50 ns high / 50 ns low), no runt pulse.
REQ-025 sel=01 from div2 -> after ack, clk_out 10 ns high / 20 ns low repeating.
REQ-026 At div100, request sel=00, then request sel=11 two cycles later while busy -> only one ack; cur_sel=00; second request ignored.
REQ-027 At div100 in PEND, assert reset for 10 ns -> clk_out=0, busy=0, no ack; after release, 50 MHz output.
REQ-028 CLKDIV_TICK_EN defined, div10 for 1 us -> exactly 10 tick pulses, each aligned with a clk_out rise.
